rx_word_assembler: RTL and testbench

RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

---
 rtl/rx_asm_pkg.sv | 16 +
 rtl/rx_idle_timer.sv | 43 ++++
 rtl/rx_word_assembler.sv | 155 +++++++++++++++
 tb/tb_rx_word_assembler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_asm_pkg.sv
// ---------------------------------------------------------------------------
// rx_asm_pkg
//   Shared definitions for the receive word assembler slice.
//   - asm_state_e      : assembler FSM state
//   - ERR_BYTE_DEFAULT : fill byte replicated across an errored word
// ---------------------------------------------------------------------------
package rx_asm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,  // no bytes of the current word held
    COLLECT = 1'b1   // 1..BYTES_PER_WORD-1 bytes held
  } asm_state_e;

  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hCC;

endpackage

// File: rtl/rx_idle_timer.sv
// ---------------------------------------------------------------------------
// rx_idle_timer
//   Counts consecutive cycles without a byte while a partial word is held.
//   expire is asserted combinationally in the TIMEOUT_CYCLES-th idle cycle,
//   so the caller can drop the word on that same clock edge. A restart in
//   that cycle suppresses expire, so a byte arriving on the expiry cycle is
//   still accepted.
//
// Ports
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   active  : a partial word is held (count only while high)
//   restart : a byte arrived this cycle (clears the count)
//   expire  : idle limit reached this cycle
// ---------------------------------------------------------------------------
module rx_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;

  assign expire = active && !restart && (idle_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (!active || restart || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rx_word_assembler.sv
// ---------------------------------------------------------------------------
// rx_word_assembler
//   Packs received bytes into BYTES_PER_WORD-byte words, first byte in
//   out[7:0]. A parity or framing error seen anywhere from word start up to
//   and including the completing byte replaces the whole word with ERR_BYTE
//   and raises err_out. out/err_out only change when a word completes.
//
//   Optional feature (macro RX_ASM_TIMEOUT_EN): a partial word is dropped
//   after TIMEOUT_CYCLES cycles without a byte, with a one-cycle timeout
//   pulse. Without the macro timeout is tied low and partial words are only
//   dropped by flush or reset.
//
// Parameters
//   BYTES_PER_WORD : bytes per output word, 1..8
//   ERR_BYTE       : fill byte for an errored word
//   TIMEOUT_CYCLES : idle-gap limit (RX_ASM_TIMEOUT_EN builds only)
//
// Ports
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   data_in   : received byte, qualified by valid
//   valid     : one-cycle strobe, byte present on data_in
//   perror    : parity error for the current word
//   ferror    : framing error for the current word
//   flush     : abandon any partial word (wins over valid)
//   out       : assembled word
//   out_valid : one-cycle pulse, new word on out
//   err_out   : word currently on out was errored
//   timeout   : one-cycle pulse, partial word dropped on idle gap
// ---------------------------------------------------------------------------
module rx_word_assembler
  import rx_asm_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  data_in,
  input  logic                        valid,
  input  logic                        perror,
  input  logic                        ferror,
  input  logic                        flush,
  output logic [8*BYTES_PER_WORD-1:0] out,
  output logic                        out_valid,
  output logic                        err_out,
  output logic                        timeout
);

  localparam int unsigned  WORD_W   = 8 * BYTES_PER_WORD;
  localparam int unsigned  CNT_W    = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  asm_state_e        state;
  logic [CNT_W-1:0]  byte_cnt;
  logic              word_err;
  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] word_next;
  logic              accept;
  logic              complete;
  logic              err_now;
  logic              expire;

  // A flushed byte is dropped outright; it neither fills a slot nor completes.
  assign accept   = valid && !flush;
  assign complete = accept && (byte_cnt == LAST_IDX);
  // Errors in the completing cycle still belong to the word being completed.
  assign err_now  = word_err | perror | ferror;

  // Completed word: held bytes plus the byte arriving now in the top slot.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path
    // can leave it unassigned and infer a latch.
    word_next = shadow;
    word_next[8*(BYTES_PER_WORD-1) +: 8] = data_in;
  end

  // NOTE: the shadow register is datapath-only and has no reset: each slot is
  // rewritten before the word that reads it completes, and out itself is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (byte_cnt == CNT_W'(k)) shadow[8*k +: 8] <= data_in;
      end
    end
  end

`ifdef RX_ASM_TIMEOUT_EN
  rx_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (state == COLLECT),
    .restart (valid),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= expire && !flush;
    end
  end
`else
  // The parameter is kept so every build shares one interface; it has no
  // effect when the idle timer is not built.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Assembler FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      word_err  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register in this
      // block sees pre-edge values, independent of statement order.
      out_valid <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        byte_cnt <= '0;
        word_err <= 1'b0;
      end else if (complete) begin
        out       <= err_now ? {BYTES_PER_WORD{ERR_BYTE}} : word_next;
        err_out   <= err_now;
        out_valid <= 1'b1;
        byte_cnt  <= '0;
        word_err  <= 1'b0;
        state     <= IDLE;
      end else if (accept) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        word_err <= err_now;
        state    <= COLLECT;
      end else if (expire) begin
        state    <= IDLE;
        byte_cnt <= '0;
        word_err <= 1'b0;
      end else begin
        // Errors while idle or between bytes stick to the current/next word.
        word_err <= err_now;
      end
    end
  end

endmodule

// File: tb/tb_rx_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_rx_word_assembler
//   Three assemblers (2, 4 and 1 bytes per word) driven by directed steps.
//   Expected words are pushed to a per-instance queue together with the cycle
//   they are due in; a negedge monitor pops and compares on every out_valid.
//   The idle-timeout section depends on RX_ASM_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_rx_word_assembler;

  typedef struct {
    logic [31:0] word;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  d  [3];
  logic        v  [3];
  logic        pe [3];
  logic        fe [3];
  logic        fl [3];
  logic        ov [3];
  logic        eo [3];
  logic        to [3];
  logic [15:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_c;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   to_count = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_word_assembler #(.BYTES_PER_WORD(2), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(d[0]), .valid(v[0]),
    .perror(pe[0]), .ferror(fe[0]), .flush(fl[0]),
    .out(out_a), .out_valid(ov[0]), .err_out(eo[0]), .timeout(to[0]));

  rx_word_assembler #(.BYTES_PER_WORD(4), .ERR_BYTE(8'hCC), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(d[1]), .valid(v[1]),
    .perror(pe[1]), .ferror(fe[1]), .flush(fl[1]),
    .out(out_b), .out_valid(ov[1]), .err_out(eo[1]), .timeout(to[1]));

  rx_word_assembler #(.BYTES_PER_WORD(1), .TIMEOUT_CYCLES(16)) dut_c (
    .clk(clk), .reset_n(reset_n), .data_in(d[2]), .valid(v[2]),
    .perror(pe[2]), .ferror(fe[2]), .flush(fl[2]),
    .out(out_c), .out_valid(ov[2]), .err_out(eo[2]), .timeout(to[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs on instance u, then return them to idle.
  task automatic step(input int u, input logic vld, input logic [7:0] b,
                      input logic p, input logic f, input logic fls);
    v[u] = vld; d[u] = b; pe[u] = p; fe[u] = f; fl[u] = fls;
    tick();
    v[u] = 1'b0; d[u] = 8'h00; pe[u] = 1'b0; fe[u] = 1'b0; fl[u] = 1'b0;
  endtask

  // Called just before the step that completes a word: due one cycle later.
  task automatic push_exp(input int u, input logic [31:0] w, input logic e);
    exp_t x;
    x.word = w;
    x.err  = e;
    x.due  = cyc + 1;
    case (u)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic score(input int u, input logic [31:0] w, input logic e);
    exp_t x;
    int   n;
    n = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
    check($sformatf("dut%0d_word_expected", u), 32'(n > 0), 32'd1);
    if (n > 0) begin
      case (u)
        0:       x = q0.pop_front();
        1:       x = q1.pop_front();
        default: x = q2.pop_front();
      endcase
      check($sformatf("dut%0d_out", u), w, x.word);
      check($sformatf("dut%0d_err_out", u), 32'(e), 32'(x.err));
      check($sformatf("dut%0d_latency_cycle", u), cyc, x.due);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ov[0]) score(0, {16'h0, out_a}, eo[0]);
      if (ov[1]) score(1, out_b, eo[1]);
      if (ov[2]) score(2, {24'h0, out_c}, eo[2]);
      if (to[0]) to_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1);
  end

  initial begin
    int c0;
    int seen;
    int tc;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'h00; v[i] = 1'b0; pe[i] = 1'b0; fe[i] = 1'b0; fl[i] = 1'b0;
    end

    // Reset state
    repeat (2) tick();
    check("rst_out_a", {16'h0, out_a}, 32'h0);
    check("rst_out_b", out_b, 32'h0);
    check("rst_out_c", {24'h0, out_c}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst_err_out%0d", i), 32'(eo[i]), 32'd0);
      check($sformatf("rst_timeout%0d", i), 32'(to[i]), 32'd0);
    end
    reset_n = 1'b1;
    tick();

    // N=2 clean pair
    step(0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h1234, 1'b0);
    step(0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    tick();

    // N=2 framing error between bytes, then hold, then clean pair
    step(0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    push_exp(0, 32'hCCCC, 1'b1);
    step(0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("hold_out_a", {16'h0, out_a}, 32'hCCCC);
    check("hold_err_out_a", 32'(eo[0]), 32'd1);
    step(0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h55AA, 1'b0);
    step(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    tick();

    // Parity error on the completing byte itself
    step(0, 1'b1, 8'h5E, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'hCCCC, 1'b1);
    step(0, 1'b1, 8'h6F, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 8'h76, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h9876, 1'b0);
    step(0, 1'b1, 8'h98, 1'b0, 1'b0, 1'b0);

    // Error while idle applies to the next word
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    step(0, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'hCCCC, 1'b1);
    step(0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);

    // Flush discards the partial byte and the pending error
    step(0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h5DC3, 1'b0);
    step(0, 1'b1, 8'h5D, 1'b0, 1'b0, 1'b0);

    // Back-to-back words on consecutive cycles
    step(0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h0201, 1'b0);
    step(0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h0403, 1'b0);
    step(0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    tick();

    // N=4: flush coincident with the fourth byte wins, then a clean word
    step(1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    step(1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    push_exp(1, 32'h04030201, 1'b0);
    step(1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    tick();

    // N=1: every byte is a word
    push_exp(2, 32'h5A, 1'b0);
    step(2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    push_exp(2, 32'hA5, 1'b0);
    step(2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    push_exp(2, 32'hCC, 1'b1);
    step(2, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    push_exp(2, 32'h0F, 1'b0);
    step(2, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    tick();

    // Errored word on dut_a so err_out is high going into reset
    step(0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    push_exp(0, 32'hCCCC, 1'b1);
    step(0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset after one byte: outputs clear, partial word is gone
    step(0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check("midrst_out_a", {16'h0, out_a}, 32'h0);
    check("midrst_err_out_a", 32'(eo[0]), 32'd0);
    check("midrst_out_valid_a", 32'(ov[0]), 32'd0);
    check("midrst_timeout_a", 32'(to[0]), 32'd0);
    check("midrst_out_b", out_b, 32'h0);
    check("midrst_out_c", {24'h0, out_c}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    step(0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'hBEEF, 1'b0);
    step(0, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef RX_ASM_TIMEOUT_EN
    // One byte then 16 idle cycles: timeout pulse, byte dropped
    step(0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (to[0]) begin
        seen = cyc;
        break;
      end
    end
    check("timeout_cycle", seen, c0 + 16);
    @(negedge clk);
    check("timeout_one_cycle", 32'(to[0]), 32'd0);
    tick();
    step(0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0);
    push_exp(0, 32'h789A, 1'b0);
    step(0, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    tick();

    // Byte arriving on the expiry cycle is accepted, no timeout
    tc = to_count;
    step(0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    repeat (15) tick();
    push_exp(0, 32'h4321, 1'b0);
    step(0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("no_timeout_on_expiry_valid", to_count, tc);
`else
    // Without the timer a partial word survives a long idle gap
    step(0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    check("timeout_tied_low", to_count, 0);
    push_exp(0, 32'h8866, 1'b0);
    step(0, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    c0 = 0; seen = 0; tc = 0;
`endif

    repeat (4) tick();
    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);
    check("dut2_queue_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
